// File: rtl/array_select_pkg.sv
// rtl/array_select_pkg.sv - shared types and constants for the array select sequencer
//
// Purpose: state encoding and command mode constants used by the sequencer
//          and its bench.
// Contents:
//   state_t      IDLE / GAP / DWELL
//   MODE_DIRECT  single cell select
//   MODE_SCAN    raster from the commanded cell to the last cell
package array_select_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    DWELL = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - combinational binary to one-hot decode
//
// Purpose: out = 1 << in.
// Ports:
//   in   IN_BITS       binary index
//   out  2**IN_BITS    one-hot result
module onehot_decoder #(
  parameter int IN_BITS = 4
) (
  input  logic [IN_BITS-1:0]    in,
  output logic [2**IN_BITS-1:0] out
);

  always_comb begin
    out     = '0;
    out[in] = 1'b1;
  end

endmodule

// File: rtl/array_select_sequencer.sv
// rtl/array_select_sequencer.sv - registered row/column select generator with gap, dwell and raster scan
//
// Purpose: accepts a target cell on a valid/ready port and drives registered
//          one-hot row/column selects with a break-before-make gap and a
//          dwell time; scan mode rasters (column fastest) to the last cell.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cmd_valid / cmd_ready      command handshake
//   cmd_mode, cmd_row, cmd_col mode (0 direct, 1 scan) and start cell
//   abort                      synchronous cancel, highest priority
//   row_sel, col_sel           registered one-hot selects
//   busy                       high whenever not in IDLE
//   done                       one-cycle pulse on normal completion
module array_select_sequencer #(
  parameter int ROW_BITS     = 4,
  parameter int COL_BITS     = 4,
  parameter int GAP_CYCLES   = 1,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_mode,
  input  logic [ROW_BITS-1:0]      cmd_row,
  input  logic [COL_BITS-1:0]      cmd_col,
  input  logic                     abort,
  output logic [2**ROW_BITS-1:0]   row_sel,
  output logic [2**COL_BITS-1:0]   col_sel,
  output logic                     busy,
  output logic                     done
);
  import array_select_pkg::*;

  localparam int MAX_CYCLES = (GAP_CYCLES > DWELL_CYCLES) ? GAP_CYCLES : DWELL_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam bit NO_GAP = (GAP_CYCLES == 0);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;
  logic                mode;
  // The accepting edge only latches the command; the sequence starts on the
  // following edge, so this flag holds off a second acceptance meanwhile.
  logic                start_pending;

  logic                  last_cell;
  logic [ROW_BITS-1:0]   adv_row, dec_row_addr;
  logic [COL_BITS-1:0]   adv_col, dec_col_addr;
  logic [2**ROW_BITS-1:0] row_dec;
  logic [2**COL_BITS-1:0] col_dec;

  always_comb begin
    last_cell = (&row) && (&col);
    adv_col   = col + 1'b1;
    adv_row   = (&col) ? row + 1'b1 : row;
    // Selects are loaded on the edge that enters DWELL. Leaving DWELL straight
    // into DWELL (no gap, scan) must decode the advanced address.
    dec_row_addr = (state == DWELL) ? adv_row : row;
    dec_col_addr = (state == DWELL) ? adv_col : col;
  end

  onehot_decoder #(.IN_BITS(ROW_BITS)) u_row_dec (.in(dec_row_addr), .out(row_dec));
  onehot_decoder #(.IN_BITS(COL_BITS)) u_col_dec (.in(dec_col_addr), .out(col_dec));

  assign cmd_ready = (state == IDLE) && !start_pending && !abort;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      row           <= '0;
      col           <= '0;
      mode          <= MODE_DIRECT;
      start_pending <= 1'b0;
      row_sel       <= '0;
      col_sel       <= '0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state         <= IDLE;
        cnt           <= '0;
        start_pending <= 1'b0;
        row_sel       <= '0;
        col_sel       <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_pending) begin
              start_pending <= 1'b0;
              if (NO_GAP) begin
                state   <= DWELL;
                cnt     <= DWELL_LOAD;
                row_sel <= row_dec;
                col_sel <= col_dec;
              end else begin
                state <= GAP;
                cnt   <= GAP_LOAD;
              end
            end else if (cmd_valid) begin
              row           <= cmd_row;
              col           <= cmd_col;
              mode          <= cmd_mode;
              start_pending <= 1'b1;
            end
          end
          GAP: begin
            if (cnt == '0) begin
              state   <= DWELL;
              cnt     <= DWELL_LOAD;
              row_sel <= row_dec;
              col_sel <= col_dec;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DWELL: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (mode == MODE_SCAN && !last_cell) begin
              row <= adv_row;
              col <= adv_col;
              if (NO_GAP) begin
                cnt     <= DWELL_LOAD;
                row_sel <= row_dec;
                col_sel <= col_dec;
              end else begin
                state   <= GAP;
                cnt     <= GAP_LOAD;
                row_sel <= '0;
                col_sel <= '0;
              end
            end else begin
              state   <= IDLE;
              row_sel <= '0;
              col_sel <= '0;
              done    <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_array_select_sequencer.sv
// tb/tb_array_select_sequencer.sv - self-checking bench for array_select_sequencer
module tb_array_select_sequencer;

  localparam int RB     = 4;
  localparam int CB     = 4;
  localparam int G      = 1;
  localparam int D      = 4;
  localparam int NR     = 2**RB;
  localparam int NC     = 2**CB;
  localparam int NCELLS = NR * NC;
  localparam int P      = G + D;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_mode;
  logic [RB-1:0] cmd_row;
  logic [CB-1:0] cmd_col;
  logic          abort;
  logic [NR-1:0] row_sel;
  logic [NC-1:0] col_sel;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  array_select_sequencer #(
    .ROW_BITS(RB), .COL_BITS(CB), .GAP_CYCLES(G), .DWELL_CYCLES(D)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_row(cmd_row), .cmd_col(cmd_col), .abort(abort),
    .row_sel(row_sel), .col_sel(col_sel), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: one command is a timeline. t counts cycles from E0+1;
  // each cell occupies P cycles (G zero cycles then D selected cycles), and
  // done follows the last cell.
  int            cyc = 0;
  bit            m_active;
  int            m_e0, m_start, m_cells;
  logic [NR-1:0] exp_row;
  logic [NC-1:0] exp_col;
  logic          exp_busy, exp_done;

  function automatic logic [NR-1:0] row_oh(input int idx);
    logic [NR-1:0] v;
    v = '0;
    v[idx / NC] = 1'b1;
    return v;
  endfunction

  function automatic logic [NC-1:0] col_oh(input int idx);
    logic [NC-1:0] v;
    v = '0;
    v[idx % NC] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      exp_row  <= '0;
      exp_col  <= '0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (abort) begin
        m_active <= 1'b0;
        exp_row  <= '0;
        exp_col  <= '0;
        exp_busy <= 1'b0;
        exp_done <= 1'b0;
      end else if (m_active) begin
        if (cyc - m_e0 >= m_cells * P) begin
          m_active <= 1'b0;
          exp_done <= 1'b1;
          exp_busy <= 1'b0;
          exp_row  <= '0;
          exp_col  <= '0;
        end else begin
          exp_busy <= 1'b1;
          exp_done <= 1'b0;
          if ((cyc - m_e0) % P >= G) begin
            exp_row <= row_oh(m_start + (cyc - m_e0) / P);
            exp_col <= col_oh(m_start + (cyc - m_e0) / P);
          end else begin
            exp_row <= '0;
            exp_col <= '0;
          end
        end
      end else begin
        exp_row  <= '0;
        exp_col  <= '0;
        exp_busy <= 1'b0;
        exp_done <= 1'b0;
        if (cmd_valid) begin
          m_active <= 1'b1;
          m_e0     <= cyc + 1;
          m_start  <= int'(cmd_row) * NC + int'(cmd_col);
          m_cells  <= cmd_mode ? NCELLS - (int'(cmd_row) * NC + int'(cmd_col)) : 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("row_sel", 32'(row_sel), 32'(exp_row));
      check("col_sel", 32'(col_sel), 32'(exp_col));
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      check("cmd_ready", 32'(cmd_ready), 32'(!m_active && !abort));
      check("onehot", 32'($onehot0(row_sel) && $onehot0(col_sel) && ((row_sel == '0) == (col_sel == '0))), 32'd1);
    end
  end

  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic send_cmd(input logic m, input int r, input int c, input bit hold,
                          input int expect_edges, input string name);
    int n = 0;
    bit rdy = 1'b0;
    cmd_mode  = m;
    cmd_row   = RB'(r);
    cmd_col   = CB'(c);
    cmd_valid = 1'b1;
    while (!rdy && n < 3000) begin
      @(negedge clk);
      rdy = cmd_ready;
      @(posedge clk);
      n++;
    end
    #2;
    if (!hold) cmd_valid = 1'b0;
    check(name, 32'(n), 32'(expect_edges));
  endtask

  task automatic wait_done(input int expect_edges, input string name);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
      seen = done;
    end
    check(name, 32'(n), 32'(expect_edges));
    #1;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_row = '0; cmd_col = '0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_row_sel", 32'(row_sel), 32'h0);
    check("rst_col_sel", 32'(col_sel), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    @(posedge clk); #2;

    // Direct (5,10)
    send_cmd(1'b0, 5, 10, 1'b0, 1, "direct_accept");
    @(posedge clk); #1;
    check("direct_e1_row", 32'(row_sel), 32'h0);
    check("direct_e1_busy", 32'(busy), 32'h1);
    @(posedge clk); #1;
    check("direct_e2_row", 32'(row_sel), 32'h0020);
    check("direct_e2_col", 32'(col_sel), 32'h0400);
    repeat (3) @(posedge clk); #1;
    check("direct_e5_row", 32'(row_sel), 32'h0020);
    check("direct_e5_col", 32'(col_sel), 32'h0400);
    #1;
    wait_done(1, "direct_done_edge");
    check("direct_e6_row", 32'(row_sel), 32'h0);
    check("direct_e6_ready", 32'(cmd_ready), 32'h1);
    @(posedge clk); #1;
    check("direct_e7_done", 32'(done), 32'h0);
    #1;

    // Scan from (15,14): two cells
    send_cmd(1'b1, 15, 14, 1'b0, 1, "scan_end_accept");
    wait_done(11, "scan_end_done");

    // Full scan from (0,0), wrap from (0,15) to (1,0)
    send_cmd(1'b1, 0, 0, 1'b0, 1, "scan_full_accept");
    repeat (80) @(posedge clk); #1;
    check("wrap_before_row", 32'(row_sel), 32'h0001);
    check("wrap_before_col", 32'(col_sel), 32'h8000);
    repeat (2) @(posedge clk); #1;
    check("wrap_after_row", 32'(row_sel), 32'h0002);
    check("wrap_after_col", 32'(col_sel), 32'h0001);
    #1;
    wait_done(1199, "scan_full_done");

    // Abort in the second dwell cycle of a scan
    send_cmd(1'b1, 3, 2, 1'b0, 1, "abort_scan_accept");
    repeat (3) @(posedge clk); #1;
    check("abort_pre_row", 32'(row_sel), 32'h0008);
    check("abort_pre_col", 32'(col_sel), 32'h0004);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    check("abort_row", 32'(row_sel), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    #1 abort = 1'b0;
    send_cmd(1'b0, 2, 7, 1'b0, 1, "after_abort_accept");
    wait_done(6, "after_abort_done");

    // Asynchronous reset between edges while dwelling
    send_cmd(1'b0, 9, 3, 1'b0, 1, "rst_mid_accept");
    repeat (3) @(posedge clk); #1;
    check("rst_mid_pre_row", 32'(row_sel), 32'h0200);
    check("rst_mid_pre_col", 32'(col_sel), 32'h0008);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_row", 32'(row_sel), 32'h0);
    check("rst_mid_col", 32'(col_sel), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #2;

    // cmd_valid held through busy: second command only after IDLE
    send_cmd(1'b0, 1, 1, 1'b1, 1, "held_accept");
    cmd_row = 4'd4;
    cmd_col = 4'd4;
    wait_done(6, "held_done1");
    @(posedge clk); #1;
    check("held_pending_busy", 32'(busy), 32'h0);
    check("held_pending_ready", 32'(cmd_ready), 32'h0);
    @(posedge clk); #1;
    check("held_second_busy", 32'(busy), 32'h1);
    #1 cmd_valid = 1'b0;
    wait_done(5, "held_done2");

    // Randomized traffic; scans start on the last row to stay short
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_mode  = ($urandom_range(0, 3) == 0);
      cmd_row   = cmd_mode ? RB'(NR - 1) : RB'($urandom_range(0, NR - 1));
      cmd_col   = CB'($urandom_range(0, NC - 1));
      abort     = ($urandom_range(0, 59) == 0);
      @(posedge clk); #2;
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    repeat (100) @(posedge clk);
    #2;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
